// File: rtl/grid_walker_pkg.sv
// Shared definitions for the grid step walker: move direction codes and FSM state encoding.
package grid_walker_pkg;

  localparam logic [1:0] DIR_XP = 2'b00;
  localparam logic [1:0] DIR_XN = 2'b01;
  localparam logic [1:0] DIR_YP = 2'b10;
  localparam logic [1:0] DIR_YN = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MOVE = 1'b1
  } state_e;

endpackage

// File: rtl/grid_step_walker_axis_step_unit.sv
// One-axis unit step with bound detection. Clamps at 0/limit by default;
// wraps toroidally when GRID_WALKER_WRAP_EN is defined.
module axis_step_unit
  import grid_walker_pkg::*;
#(
  parameter int COORD_W = 5
) (
  input  logic [COORD_W-1:0] coord,
  input  logic [COORD_W-1:0] limit,
  input  logic               enable,
  input  logic               decrement,
  output logic [COORD_W-1:0] next_coord,
  output logic               at_bound
);

  logic [COORD_W:0] coord_ext;
  logic [COORD_W:0] stepped;
  logic             out_of_range;

  // One extra bit exposes underflow below 0 and lets limits below the full range be compared.
  always_comb begin
    coord_ext    = {1'b0, coord};
    stepped      = decrement ? (coord_ext - (COORD_W+1)'(1)) : (coord_ext + (COORD_W+1)'(1));
    out_of_range = decrement ? stepped[COORD_W] : (stepped > {1'b0, limit});
    next_coord   = coord;
    at_bound     = 1'b0;
    if (enable) begin
      if (out_of_range) begin
        at_bound = 1'b1;
`ifdef GRID_WALKER_WRAP_EN
        next_coord = decrement ? limit : '0;
`else
        next_coord = coord;
`endif
      end else begin
        next_coord = stepped[COORD_W-1:0];
      end
    end
  end

endmodule

// File: rtl/grid_step_walker.sv
// Registered 2-D position tracker executing multi-step moves one unit per clock.
// Bound policy is clamp by default; define GRID_WALKER_WRAP_EN for a toroidal grid.
module grid_step_walker
  import grid_walker_pkg::*;
#(
  parameter int COORD_W = 5,
  parameter int STEP_W  = 2,
  parameter int X_MAX   = 31,
  parameter int Y_MAX   = 31,
  parameter int X_INIT  = 0,
  parameter int Y_INIT  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_dir,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               load,
  input  logic [COORD_W-1:0] load_x,
  input  logic [COORD_W-1:0] load_y,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               busy,
  output logic               done,
  output logic               hit_wall
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [1:0]          dir_q, dir_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;

  logic                x_en, y_en, x_bound, y_bound;
  logic [COORD_W-1:0]  x_next, y_next;

  assign x_en = (state_q == ST_MOVE) && ((dir_q == DIR_XP) || (dir_q == DIR_XN));
  assign y_en = (state_q == ST_MOVE) && ((dir_q == DIR_YP) || (dir_q == DIR_YN));

  axis_step_unit #(.COORD_W(COORD_W)) u_axis_x (
    .coord      (x_q),
    .limit      (X_LIM),
    .enable     (x_en),
    .decrement  (dir_q == DIR_XN),
    .next_coord (x_next),
    .at_bound   (x_bound)
  );

  axis_step_unit #(.COORD_W(COORD_W)) u_axis_y (
    .coord      (y_q),
    .limit      (Y_LIM),
    .enable     (y_en),
    .decrement  (dir_q == DIR_YN),
    .next_coord (y_next),
    .at_bound   (y_bound)
  );

  assign cmd_ready = (state_q == ST_IDLE) && !load;

  // Load beats a same-cycle command; a zero-step command finishes without entering MOVE.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    hit_d   = hit_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          x_d = (load_x > X_LIM) ? X_LIM : load_x;
          y_d = (load_y > Y_LIM) ? Y_LIM : load_y;
        end else if (cmd_valid) begin
          dir_d = cmd_dir;
          rem_d = cmd_steps;
          hit_d = 1'b0;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_MOVE;
          end
        end
      end
      ST_MOVE: begin
        x_d   = x_next;
        y_d   = y_next;
        rem_d = rem_q - STEP_W'(1);
        if (x_bound || y_bound) begin
          hit_d = 1'b1;
        end
        if (rem_q == STEP_W'(1)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= COORD_W'(X_INIT);
      y_q     <= COORD_W'(Y_INIT);
      rem_q   <= '0;
      dir_q   <= DIR_XP;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign busy     = (state_q == ST_MOVE);
  assign done     = done_q;
  assign hit_wall = hit_q;

endmodule

// File: tb/tb_grid_step_walker.sv
// Self-checking bench for grid_step_walker: per-cycle comparison against a
// behavioural position model plus hand-computed directed expectations.
module tb_grid_step_walker;

  localparam int COORD_W = 5;
  localparam int STEP_W  = 2;
  localparam int X_MAX   = 31;
  localparam int Y_MAX   = 20;
  localparam int X_INIT  = 0;
  localparam int Y_INIT  = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_dir;
  logic [STEP_W-1:0]  cmd_steps;
  logic               load;
  logic [COORD_W-1:0] load_x;
  logic [COORD_W-1:0] load_y;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic               busy;
  logic               done;
  logic               hit_wall;

  int n_checks = 0;
  int n_errors = 0;

  grid_step_walker #(
    .COORD_W(COORD_W), .STEP_W(STEP_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .load      (load),
    .load_x    (load_x),
    .load_y    (load_y),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .hit_wall  (hit_wall)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: plain integers, moves resolved with signed arithmetic against the grid limits.
  int m_x, m_y, m_rem, m_dir;
  bit m_busy, m_done, m_hit, m_valid = 1'b0;

  function automatic int step_axis(input int v, input int d, input int vmax, inout bit hit);
    int nv;
    nv = v + d;
    if (nv < 0 || nv > vmax) begin
      hit = 1'b1;
`ifdef GRID_WALKER_WRAP_EN
      return (nv < 0) ? vmax : 0;
`else
      return v;
`endif
    end
    return nv;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_x = X_INIT; m_y = Y_INIT; m_rem = 0; m_dir = 0;
      m_busy = 0; m_done = 0; m_hit = 0; m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (m_busy) begin
        case (m_dir)
          0: m_x = step_axis(m_x, 1, X_MAX, m_hit);
          1: m_x = step_axis(m_x, -1, X_MAX, m_hit);
          2: m_y = step_axis(m_y, 1, Y_MAX, m_hit);
          default: m_y = step_axis(m_y, -1, Y_MAX, m_hit);
        endcase
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end else if (load) begin
        m_x = (int'(load_x) > X_MAX) ? X_MAX : int'(load_x);
        m_y = (int'(load_y) > Y_MAX) ? Y_MAX : int'(load_y);
      end else if (cmd_valid) begin
        m_dir = int'(cmd_dir);
        m_rem = int'(cmd_steps);
        m_hit = 0;
        if (m_rem == 0) m_done = 1;
        else m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check_output("model_x", int'(x), m_x);
      check_output("model_y", int'(y), m_y);
      check_output("model_busy", int'(busy), int'(m_busy));
      check_output("model_done", int'(done), int'(m_done));
      check_output("model_hit_wall", int'(hit_wall), int'(m_hit));
      check_output("model_cmd_ready", int'(cmd_ready), int'(!m_busy && !load));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input bit v, input int dir, input int steps,
                                input bit ld, input int lx, input int ly);
    cmd_valid = v;
    cmd_dir   = 2'(dir);
    cmd_steps = STEP_W'(steps);
    load      = ld;
    load_x    = COORD_W'(lx);
    load_y    = COORD_W'(ly);
  endtask

  task automatic idle_inputs();
    apply_stimulus(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    cycle(); cycle();
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_x", int'(x), 0);
    check_output("reset_y", int'(y), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);

    // Test 1: +x by 3 from origin
    apply_stimulus(1, 0, 3, 0, 0, 0);
    cycle(); idle_inputs();
    @(negedge clk); check_output("t1_busy", int'(busy), 1);
    check_output("t1_x0", int'(x), 0);
    cycle(); @(negedge clk); check_output("t1_x1", int'(x), 1);
    cycle(); @(negedge clk); check_output("t1_x2", int'(x), 2);
    cycle(); @(negedge clk);
    check_output("t1_x3", int'(x), 3);
    check_output("t1_done", int'(done), 1);
    check_output("t1_busy_end", int'(busy), 0);

    // Test 2: load, then -x by 3 from x=1 clamps at 0
    apply_stimulus(0, 0, 0, 1, 5, 5);
    cycle(); idle_inputs();
    @(negedge clk); check_output("t2_load_x", int'(x), 5);
    apply_stimulus(0, 0, 0, 1, 1, 5);
    cycle();
    apply_stimulus(1, 1, 3, 0, 0, 0);
    cycle(); idle_inputs();
    cycle(); @(negedge clk);
    check_output("t2_x_first", int'(x), 0);
    check_output("t2_hit_first", int'(hit_wall), 0);
    cycle(); @(negedge clk); check_output("t2_hit", int'(hit_wall), 1);
    cycle(); @(negedge clk);
    check_output("t2_done", int'(done), 1);
    check_output("t2_x_held", int'(x), 0);

    // Test 3: zero-step command clears hit_wall and finishes next cycle
    apply_stimulus(1, 2, 0, 0, 0, 0);
    cycle(); idle_inputs();
    @(negedge clk);
    check_output("t3_done", int'(done), 1);
    check_output("t3_busy", int'(busy), 0);
    check_output("t3_hit_cleared", int'(hit_wall), 0);
    check_output("t3_y", int'(y), 5);

    // Test 4: load at far corner (y clamps to Y_MAX), +x by 2
    apply_stimulus(0, 0, 0, 1, 31, 31);
    cycle(); idle_inputs();
    @(negedge clk); check_output("t4_load_y_clamp", int'(y), 20);
    apply_stimulus(1, 0, 2, 0, 0, 0);
    cycle(); idle_inputs();
    cycle(); cycle(); @(negedge clk);
`ifdef GRID_WALKER_WRAP_EN
    check_output("t4_x_wrapped", int'(x), 1);
`else
    check_output("t4_x_clamped", int'(x), 31);
`endif
    check_output("t4_hit", int'(hit_wall), 1);

    // Upper y bound: from y=19, +y by 3
    apply_stimulus(0, 0, 0, 1, 0, 19);
    cycle();
    apply_stimulus(1, 2, 3, 0, 0, 0);
    cycle(); idle_inputs();
    cycle(); cycle(); cycle(); @(negedge clk);
`ifdef GRID_WALKER_WRAP_EN
    check_output("ty_wrapped", int'(y), 1);
`else
    check_output("ty_clamped", int'(y), 20);
`endif

    // Test 5: load and cmd_valid together; command waits until load drops
    apply_stimulus(1, 2, 1, 1, 7, 9);
    @(negedge clk); check_output("t5_ready_low", int'(cmd_ready), 0);
    cycle();
    apply_stimulus(1, 2, 1, 0, 0, 0);
    @(negedge clk);
    check_output("t5_load_x", int'(x), 7);
    check_output("t5_pending_ready", int'(cmd_ready), 1);
    cycle(); idle_inputs();
    cycle(); @(negedge clk);
    check_output("t5_y", int'(y), 10);
    check_output("t5_done", int'(done), 1);

    // Back-to-back one-step moves with cmd_valid held high
    apply_stimulus(1, 0, 1, 0, 0, 0);
    cycle(); cycle();
    @(negedge clk); check_output("bb_ready_on_done", int'(cmd_ready), 1);
    cycle(); idle_inputs();
    cycle(); @(negedge clk); check_output("bb_x", int'(x), 9);

    // Test 6: reset mid-move aborts with no done pulse
    apply_stimulus(1, 0, 3, 0, 0, 0);
    cycle(); idle_inputs();
    cycle();
    reset = 1'b1;
    cycle();
    @(negedge clk);
    check_output("t6_x_init", int'(x), 0);
    check_output("t6_busy", int'(busy), 0);
    reset = 1'b0;
    cycle(); @(negedge clk);
    check_output("t6_no_done", int'(done), 0);

    cycle(); cycle();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
